// File: rtl/scroll_latch_if.sv
// Time-multiplexed master bus seen by scroll_latch: slot phase, address/data,
// write and latch strobes, plus the master CPU data bus for back-colour captures.
interface scroll_latch_if;
    logic        CLK_2H;
    logic [12:0] A;
    logic [7:0]  D;
    logic        nWE;
    logic        nLATCH0;
    logic        nLATCH1;
    logic        nBACKCOLOR;
    logic [7:0]  MD;

    modport master (
        output CLK_2H, A, D, nWE, nLATCH0, nLATCH1, nBACKCOLOR, MD
    );

    modport slave (
        input  CLK_2H, A, D, nWE, nLATCH0, nLATCH1, nBACKCOLOR, MD
    );
endinterface

// File: rtl/scroll_latch.sv
// Scroll/priority latch for two tilemap layers plus back-colour capture.
// Define DOUBLE_BUFFER_EN to stage writes in shadows committed at vblank start.
module scroll_latch (
    input  logic          CLK_6M,
    input  logic          rst,
    input  logic          nVBLANK,
    scroll_latch_if.slave bus,
    output logic [8:0]    scroll0_x,
    output logic [8:0]    scroll1_x,
    output logic [7:0]    scroll0_y,
    output logic [7:0]    scroll1_y,
    output logic [2:0]    prio0,
    output logic [2:0]    prio1,
    output logic [7:0]    backcolor,
    output logic          wr_pulse
);
    logic [1:0] nlatch;
    logic [1:0] prev_nlatch_reg;
    logic       prev_clk_2h_reg;
    logic       prev_nbackcolor_reg;
    logic       new_slot;
    logic [1:0] accept;
    logic       commit;
    logic [7:0] backcolor_reg;
    logic       wr_pulse_reg;
    logic       unused_addr;

    assign nlatch      = {bus.nLATCH1, bus.nLATCH0};
    assign new_slot    = prev_clk_2h_reg != bus.CLK_2H;
    assign unused_addr = ^bus.A[12:2];

`ifdef DOUBLE_BUFFER_EN
    logic prev_nvblank_reg;

    assign commit = prev_nvblank_reg & ~nVBLANK;

    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            prev_nvblank_reg <= 1'b1;
        end else begin
            prev_nvblank_reg <= nVBLANK;
        end
    end
`else
    logic unused_vblank;

    assign unused_vblank = nVBLANK;
    assign commit        = 1'b0;
`endif

    // Reset leaves the strobe history "high" so a strobe held low through
    // reset counts as a fresh assertion on the first cycle afterwards.
    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            prev_nlatch_reg     <= 2'b11;
            prev_clk_2h_reg     <= 1'b0;
            prev_nbackcolor_reg <= 1'b1;
            backcolor_reg       <= 8'd0;
            wr_pulse_reg        <= 1'b0;
        end else begin
            prev_nlatch_reg     <= nlatch;
            prev_clk_2h_reg     <= bus.CLK_2H;
            prev_nbackcolor_reg <= bus.nBACKCOLOR;
            wr_pulse_reg        <= |accept;
            if (prev_nbackcolor_reg && !bus.nBACKCOLOR) begin
                backcolor_reg <= bus.MD;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_layer
            logic [8:0] x_reg, x_next, x_out;
            logic [7:0] y_reg, y_next, y_out;
            logic [2:0] prio_reg, prio_next, prio_out;

            assign accept[gi] = ~nlatch[gi] & ~bus.nWE & (prev_nlatch_reg[gi] | new_slot);

            always_comb begin
                x_next    = x_reg;
                y_next    = y_reg;
                prio_next = prio_reg;
                if (accept[gi]) begin
                    case (bus.A[1:0])
                        2'd0: begin
                            x_next[8] = bus.D[0];
                            prio_next = bus.D[3:1];
                        end
                        2'd1:    x_next[7:0] = bus.D;
                        2'd2:    y_next      = bus.D;
                        default: ;
                    endcase
                end
            end

            // Without double buffering these registers are the active outputs.
            always_ff @(posedge CLK_6M) begin
                if (rst) begin
                    x_reg    <= 9'd0;
                    y_reg    <= 8'd0;
                    prio_reg <= 3'd0;
                end else begin
                    x_reg    <= x_next;
                    y_reg    <= y_next;
                    prio_reg <= prio_next;
                end
            end

`ifdef DOUBLE_BUFFER_EN
            logic [8:0] x_act_reg;
            logic [7:0] y_act_reg;
            logic [2:0] prio_act_reg;

            // Commit from the next-state values so a coincident write is included.
            always_ff @(posedge CLK_6M) begin
                if (rst) begin
                    x_act_reg    <= 9'd0;
                    y_act_reg    <= 8'd0;
                    prio_act_reg <= 3'd0;
                end else if (commit) begin
                    x_act_reg    <= x_next;
                    y_act_reg    <= y_next;
                    prio_act_reg <= prio_next;
                end
            end

            assign x_out    = x_act_reg;
            assign y_out    = y_act_reg;
            assign prio_out = prio_act_reg;
`else
            assign x_out    = x_reg;
            assign y_out    = y_reg;
            assign prio_out = prio_reg;
`endif
        end
    endgenerate

    logic unused_commit;
    assign unused_commit = commit;

    assign scroll0_x = g_layer[0].x_out;
    assign scroll1_x = g_layer[1].x_out;
    assign scroll0_y = g_layer[0].y_out;
    assign scroll1_y = g_layer[1].y_out;
    assign prio0     = g_layer[0].prio_out;
    assign prio1     = g_layer[1].prio_out;
    assign backcolor = backcolor_reg;
    assign wr_pulse  = wr_pulse_reg;
endmodule

// File: doc/scroll_latch.md
# scroll_latch

Master-bus responder for the scroll/priority and back-colour latch writes issued by the CPU subsystem. It samples the time-multiplexed master bus (A, D, nWE, nLATCH0, nLATCH1) once per CPU slot and decodes writes into per-layer scroll X/Y and priority registers. It also captures the back-colour byte from MD on nBACKCOLOR. Register updates are optionally double-buffered and committed at the start of vertical blank, and the outputs feed the tilemap renderer and the colour mixer.

## Interface
- No parameters.
- CLK_6M  in  1  pixel clock; sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- CLK_2H  in  1  slot phase: 0 = master CPU slot, 1 = sub CPU slot.
- nVBLANK  in  1  active-low vertical blank.
- A  in  13  multiplexed master address bus; only A[1:0] decoded.
- D  in  8  multiplexed master data bus.
- nWE  in  1  multiplexed active-low write enable.
- nLATCH0  in  1  active-low select, layer 0 register set.
- nLATCH1  in  1  active-low select, layer 1 register set.
- nBACKCOLOR  in  1  active-low back-colour latch select (master only).
- MD  in  8  master CPU data bus.
- scroll0_x / scroll1_x  out  9  active X scroll, layers 0/1.
- scroll0_y / scroll1_y  out  8  active Y scroll, layers 0/1.
- prio0 / prio1  out  3  active priority, layers 0/1.
- backcolor  out  8  back-colour index.
- wr_pulse  out  1  one-cycle pulse on every accepted latch write (debug/verification).

## Operation
- Register map per layer (selected by nLATCH0 / nLATCH1):
  - A[1:0]=0: D[0] → X[8]; D[3:1] → prio.
  - A[1:0]=1: D[7:0] → X[7:0].
  - A[1:0]=2: D[7:0] → Y.
  - A[1:0]=3: ignored. The write is still accepted and wr_pulse fires.
- Write acceptance. Registered copies of nLATCH0, nLATCH1 and CLK_2H are kept (prev_*). A write to layer n is accepted on a rising edge where all of the following hold:
  - nLATCHn=0.
  - nWE=0.
  - prev_nLATCHn=1 or prev_CLK_2H≠CLK_2H, i.e. this is the first cycle of a new strobe or of a new slot.
- Acceptance limits:
  - At most one write per layer per slot.
  - A strobe held low across one slot does not re-write.
  - Back-to-back master/sub slots each write.
- Both strobes low in the same cycle: both layers are written with the same A/D; wr_pulse fires once.
- Writes land in shadow registers (sh0_*, sh1_*).
- Commit: on the nVBLANK falling edge (prev_nVBLANK=1, nVBLANK=0), all shadows are copied to the active outputs.
- Write coincident with commit: the shadow is updated and the committed value includes that write.
- backcolor: loaded from MD on the first cycle of an nBACKCOLOR low assertion (prev=1, now=0). It is independent of nWE and never buffered.
- Reset:
  - All shadows and active outputs go to 0.
  - backcolor=0, wr_pulse=0.
  - prev_nLATCH0/1 and prev_nBACKCOLOR go to 1; prev_nVBLANK goes to 1; prev_CLK_2H goes to 0.
  - A strobe already low when rst deasserts is treated as a new assertion on the first cycle after reset.

## Timing
- Acceptance is decided on edge k, and the shadow updates at edge k.
- wr_pulse is high for exactly the cycle following edge k.
- Active outputs update on the same edge as the detected vblank fall (DOUBLE_BUFFER_EN defined), or on edge k (undefined).
- backcolor updates on the edge detecting the nBACKCOLOR fall.
- No combinational paths from inputs to outputs; all outputs are registered.
- rst has priority over every other event on the same edge.

## Configuration
- DOUBLE_BUFFER_EN defined: shadow/commit behaviour as above. Active outputs change only at vblank start.
- DOUBLE_BUFFER_EN undefined:
  - Shadows are removed and writes go directly to the active outputs at edge k.
  - The nVBLANK input is ignored.
  - backcolor and wr_pulse behaviour is unchanged.

## Test plan
- Reset release with both strobes high and all inputs idle → all outputs 0 and wr_pulse never asserts.
- Master slot (CLK_2H=0), nLATCH0=0, nWE=0, A=1, D=0xA5, followed by A=0, D=0x0F in the next master slot → wr_pulse fires twice and the shadows become X=0x1A5, prio=7. With DOUBLE_BUFFER_EN: scroll0_x stays 0 until the nVBLANK fall, then becomes 0x1A5 and prio0=7. Without it: scroll0_x=0x1A5 one cycle after the second write.
- nLATCH1=0 held across 6 cycles within one slot, with A=2, D=0x33 → exactly one wr_pulse, and scroll1_y=0x33 after commit.
- Master writes A=2, D=0x10 to layer 0, immediately followed by a sub-slot write A=2, D=0x20 with nLATCH0 held low through the phase change → two wr_pulses, and scroll0_y=0x20 after commit.
- A layer 0 write of A=1, D=0x44 on the same edge as the nVBLANK fall, with DOUBLE_BUFFER_EN → scroll0_x[7:0]=0x44 in the very next cycle.
- nBACKCOLOR low with MD=0x7E and nWE=1, then rst asserted mid-strobe → backcolor=0x7E. rst then clears it to 0, and after rst deasserts with the strobe still low, backcolor reloads 0x7E.
